// File: rtl/m_rst_seq.sv
// Reset sequencer: merges switch, watchdog and soft reset sources, holds and then
// releases the downstream reset stages in order, and services the watchdog while running.
module m_rst_seq #(
    parameter int N_STG     = 3,
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_DLY = 8,
    parameter int KICK_PER  = 100,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_rst_n,
    input  logic             wdt_rst_n,
    input  logic             soft_rst_req,
    input  logic             kick_en,
    input  logic             cause_clr,
    output logic             wdi,
    output logic [N_STG-1:0] stg_rst_n,
    output logic             seq_done,
    output logic [2:0]       rst_cause,
    output logic [CNT_W-1:0] wdt_cnt
);

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int DLY_W  = $clog2(STAGE_DLY + 1);
    localparam int KICK_W = $clog2(KICK_PER);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t             state, state_nx;
    logic [HOLD_W-1:0]  hold_cnt, hold_nx;
    logic [DLY_W-1:0]   dly_cnt, dly_nx;
    logic [KICK_W-1:0]  kick_cnt, kick_nx;
    logic [N_STG-1:0]   stg_nx;
    logic               done_nx;
    logic               wdi_nx;
    logic [2:0]         cause_nx;
    logic [CNT_W-1:0]   wdt_cnt_nx;

    logic sw_meta, sw_sync, sw_prev;
    logic wdt_meta, wdt_sync, wdt_prev;
    logic src_any, sw_fall, wdt_fall;

    // Synchroniser and edge-history flops idle high so a reset release is never
    // mistaken for a fresh source assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta  <= 1'b1;
            sw_sync  <= 1'b1;
            sw_prev  <= 1'b1;
            wdt_meta <= 1'b1;
            wdt_sync <= 1'b1;
            wdt_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value,
            // which is what makes this a two-stage shift rather than a single wire.
            sw_meta  <= sw_rst_n;
            sw_sync  <= sw_meta;
            sw_prev  <= sw_sync;
            wdt_meta <= wdt_rst_n;
            wdt_sync <= wdt_meta;
            wdt_prev <= wdt_sync;
        end
    end

    assign src_any  = ~sw_sync | ~wdt_sync | soft_rst_req;
    assign sw_fall  = sw_prev & ~sw_sync;
    assign wdt_fall = wdt_prev & ~wdt_sync;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nx = state;
        hold_nx  = hold_cnt;
        dly_nx   = dly_cnt;
        kick_nx  = kick_cnt;
        stg_nx   = stg_rst_n;
        done_nx  = seq_done;
        wdi_nx   = wdi;

        if (src_any) begin
            state_nx = S_HOLD;
            hold_nx  = HOLD_W'(HOLD_CYC);
            stg_nx   = '0;
            done_nx  = 1'b0;
            wdi_nx   = 1'b0;
            kick_nx  = '0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        stg_nx = N_STG'(1);
                        dly_nx = DLY_W'(STAGE_DLY - 1);
                        if (&stg_nx) begin
                            state_nx = S_RUN;
                            done_nx  = 1'b1;
                            kick_nx  = '0;
                        end else begin
                            state_nx = S_RELEASE;
                        end
                    end else begin
                        hold_nx = hold_cnt - 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (dly_cnt == '0) begin
                        // Thermometer shift: the next stage up joins the released set.
                        stg_nx = (stg_rst_n << 1) | N_STG'(1);
                        dly_nx = DLY_W'(STAGE_DLY - 1);
                        if (&stg_nx) begin
                            state_nx = S_RUN;
                            done_nx  = 1'b1;
                            kick_nx  = '0;
                        end
                    end else begin
                        dly_nx = dly_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (kick_en) begin
                        if (kick_cnt == KICK_W'(KICK_PER - 1)) begin
                            kick_nx = '0;
                            wdi_nx  = ~wdi;
                        end else begin
                            kick_nx = kick_cnt + 1'b1;
                        end
                    end else begin
                        kick_nx = '0;
                    end
                end
                default: state_nx = S_HOLD;
            endcase
        end
    end

    // A clear and a new cause on the same edge: the new cause survives.
    assign cause_nx   = (cause_clr ? 3'b000 : rst_cause) | {wdt_fall, sw_fall, soft_rst_req};
    assign wdt_cnt_nx = (wdt_fall && (wdt_cnt != '1)) ? wdt_cnt + 1'b1 : wdt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HOLD;
            hold_cnt  <= HOLD_W'(HOLD_CYC);
            dly_cnt   <= '0;
            kick_cnt  <= '0;
            stg_rst_n <= '0;
            seq_done  <= 1'b0;
            wdi       <= 1'b0;
            rst_cause <= 3'b000;
            wdt_cnt   <= '0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            dly_cnt   <= dly_nx;
            kick_cnt  <= kick_nx;
            stg_rst_n <= stg_nx;
            seq_done  <= done_nx;
            wdi       <= wdi_nx;
            rst_cause <= cause_nx;
            wdt_cnt   <= wdt_cnt_nx;
        end
    end

endmodule

// File: tb/tb_m_rst_seq.sv
// Directed bench for m_rst_seq: default-parameter instance for sequencing and causes,
// plus a single-stage, 2-bit-counter instance for the bypass and saturation corners.
module tb_m_rst_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw_rst_n = 1'b1;
    logic wdt_rst_n = 1'b1;
    logic soft_rst_req = 1'b0;
    logic kick_en = 1'b1;
    logic cause_clr = 1'b0;
    logic       wdi;
    logic [2:0] stg;
    logic       seq_done;
    logic [2:0] cause;
    logic [7:0] cnt;

    logic       wdt2_n = 1'b1;
    logic       clr2 = 1'b0;
    logic       wdi2;
    logic [0:0] stg2;
    logic       done2;
    logic [2:0] cause2;
    logic [1:0] cnt2;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_edge = -1;

    always #5 clk = ~clk;

    m_rst_seq dut (
        .clk(clk), .rst_n(rst_n), .sw_rst_n(sw_rst_n), .wdt_rst_n(wdt_rst_n),
        .soft_rst_req(soft_rst_req), .kick_en(kick_en), .cause_clr(cause_clr),
        .wdi(wdi), .stg_rst_n(stg), .seq_done(seq_done), .rst_cause(cause), .wdt_cnt(cnt)
    );

    m_rst_seq #(.N_STG(1), .HOLD_CYC(4), .STAGE_DLY(2), .KICK_PER(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sw_rst_n(1'b1), .wdt_rst_n(wdt2_n),
        .soft_rst_req(1'b0), .kick_en(1'b1), .cause_clr(clr2),
        .wdi(wdi2), .stg_rst_n(stg2), .seq_done(done2), .rst_cause(cause2), .wdt_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cur_edge, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cur_edge++;
    endtask

    task automatic go_to(input int k);
        while (cur_edge < k) tick();
    endtask

    task automatic chk_stg(input string tag, input logic [2:0] exp_stg, input logic exp_done);
        check({tag, ".stg"}, 32'(stg), 32'(exp_stg));
        check({tag, ".done"}, 32'(seq_done), 32'(exp_done));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_stg("por", 3'b000, 1'b0);
        check("por.wdi", 32'(wdi), 32'h0);
        check("por.cause", 32'(cause), 32'h0);
        check("por.cnt", 32'(cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Power-on sequence and first kicks
        go_to(15);  chk_stg("hold15", 3'b000, 1'b0);
        go_to(16);  chk_stg("rel16", 3'b001, 1'b0);
        go_to(23);  chk_stg("rel23", 3'b001, 1'b0);
        go_to(24);  chk_stg("rel24", 3'b011, 1'b0);
        go_to(31);  chk_stg("rel31", 3'b011, 1'b0);
        go_to(32);  chk_stg("run32", 3'b111, 1'b1);
        go_to(131); check("wdi131", 32'(wdi), 32'h0);
        go_to(132); check("wdi132", 32'(wdi), 32'h1);
        go_to(231); check("wdi231", 32'(wdi), 32'h1);
        go_to(232); check("wdi232", 32'(wdi), 32'h0);

        // Kick disabled: wdi must stay frozen past the next would-be toggle
        go_to(240); kick_en = 1'b0;
        go_to(339); check("wdi_frozen", 32'(wdi), 32'h0);

        // Watchdog reset pulse, 3 cycles low
        go_to(340); wdt_rst_n = 1'b0;
        go_to(342); chk_stg("wdt342", 3'b111, 1'b1);
        go_to(343); wdt_rst_n = 1'b1;
        chk_stg("wdt343", 3'b000, 1'b0);
        check("wdt343.wdi", 32'(wdi), 32'h0);
        check("wdt343.cause", 32'(cause), 32'h4);
        check("wdt343.cnt", 32'(cnt), 32'h1);
        go_to(350); cause_clr = 1'b1;
        go_to(351); cause_clr = 1'b0;
        check("clr351.cause", 32'(cause), 32'h0);
        go_to(361); chk_stg("wdt361", 3'b000, 1'b0);
        go_to(362); chk_stg("wdt362", 3'b001, 1'b0);

        // Switch reset for 5 cycles while only stage 0 is released
        go_to(363); sw_rst_n = 1'b0;
        go_to(365); chk_stg("sw365", 3'b001, 1'b0);
        go_to(366); chk_stg("sw366", 3'b000, 1'b0);
        check("sw366.cause", 32'(cause), 32'h2);
        check("sw366.cnt", 32'(cnt), 32'h1);
        go_to(368); sw_rst_n = 1'b1;
        go_to(386); chk_stg("sw386", 3'b000, 1'b0);
        go_to(387); chk_stg("sw387", 3'b001, 1'b0);
        go_to(395); chk_stg("sw395", 3'b011, 1'b0);
        go_to(403); chk_stg("sw403", 3'b111, 1'b1);

        // Clear, then a second watchdog event to leave cause = 100
        go_to(404); cause_clr = 1'b1;
        go_to(405); cause_clr = 1'b0;
        check("clr405.cause", 32'(cause), 32'h0);
        wdt_rst_n = 1'b0;
        go_to(408); wdt_rst_n = 1'b1;
        check("wdt408.cause", 32'(cause), 32'h4);
        check("wdt408.cnt", 32'(cnt), 32'h2);
        go_to(426); chk_stg("wdt426", 3'b000, 1'b0);
        go_to(427); chk_stg("wdt427", 3'b001, 1'b0);

        // Soft reset together with cause_clr: the new cause wins
        go_to(429);
        check("soft429.cause", 32'(cause), 32'h4);
        soft_rst_req = 1'b1;
        cause_clr = 1'b1;
        go_to(430);
        soft_rst_req = 1'b0;
        cause_clr = 1'b0;
        check("soft430.cause", 32'(cause), 32'h1);
        chk_stg("soft430", 3'b000, 1'b0);
        go_to(446); chk_stg("soft446", 3'b000, 1'b0);
        go_to(447); chk_stg("soft447", 3'b001, 1'b0);
        go_to(455); chk_stg("soft455", 3'b011, 1'b0);
        go_to(463); chk_stg("soft463", 3'b111, 1'b1);
        kick_en = 1'b1;
        go_to(562); check("wdi562", 32'(wdi), 32'h0);
        go_to(563); check("wdi563", 32'(wdi), 32'h1);

        // Asynchronous reset while running, checked before any clock edge
        go_to(570);
        #2 rst_n = 1'b0;
        #1;
        chk_stg("async", 3'b000, 1'b0);
        check("async.wdi", 32'(wdi), 32'h0);
        check("async.cause", 32'(cause), 32'h0);
        check("async.cnt", 32'(cnt), 32'h0);

        // Single-stage instance: HOLD expiry goes straight to RUN; 2-bit saturation
        @(negedge clk);
        rst_n = 1'b1;
        cur_edge = -1;
        go_to(3);
        check("s1.stg3", 32'(stg2), 32'h0);
        check("s1.done3", 32'(done2), 32'h0);
        go_to(4);
        check("s1.stg4", 32'(stg2), 32'h1);
        check("s1.done4", 32'(done2), 32'h1);
        go_to(7); check("s1.wdi7", 32'(wdi2), 32'h0);
        go_to(8); check("s1.wdi8", 32'(wdi2), 32'h1);
        for (int p = 0; p < 5; p++) begin
            automatic int b = 10 + 10 * p;
            automatic logic [1:0] exp_cnt = (p < 3) ? 2'(p + 1) : 2'd3;
            go_to(b); wdt2_n = 1'b0;
            go_to(b + 2); wdt2_n = 1'b1;
            check($sformatf("s1.cnt_pre%0d", p), 32'(cnt2), 32'((p < 3) ? p : 3));
            go_to(b + 3);
            check($sformatf("s1.cnt%0d", p), 32'(cnt2), 32'(exp_cnt));
            check($sformatf("s1.stg_rst%0d", p), 32'(stg2), 32'h0);
        end
        go_to(54);
        check("s1.cause54", 32'(cause2), 32'h4);
        clr2 = 1'b1;
        go_to(55);
        clr2 = 1'b0;
        check("s1.cause55", 32'(cause2), 32'h0);
        check("s1.cnt55", 32'(cnt2), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
